// File: rtl/ispm_shared_pkg.sv
// ispm_pkg: bus FSM state encoding, default data width W and starve-counter sizing helper
package ispm_pkg;
  localparam int DATA_BYTES_DEF = 4;
  localparam int W = 8 * DATA_BYTES_DEF;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} bus_state_e;
  function automatic int starve_cnt_bits(input int limit);
    return $clog2(limit + 1);
  endfunction
endpackage

// File: rtl/ispm_shared_if.sv
// ispm_shared_if: fetch (r), load/store (rw) and bus-slave signal bundle; slave = scratchpad, master = core/bus side
interface ispm_shared_if #(parameter int ADDR_BITS = 12, parameter int DATA_BYTES = 4);
  localparam int DW = 8 * DATA_BYTES;
  logic [ADDR_BITS-1:0]  io_core_r_addr;
  logic                  io_core_r_enable;
  logic [DW-1:0]         io_core_r_data_out;
  logic [ADDR_BITS-1:0]  io_core_rw_addr;
  logic                  io_core_rw_enable;
  logic                  io_core_rw_write;
  logic [DATA_BYTES-1:0] io_core_rw_byte_en;
  logic [DW-1:0]         io_core_rw_data_in;
  logic [DW-1:0]         io_core_rw_data_out;
  logic [ADDR_BITS-1:0]  io_bus_addr;
  logic                  io_bus_enable;
  logic                  io_bus_write;
  logic [DW-1:0]         io_bus_data_in;
  logic [DW-1:0]         io_bus_data_out;
  logic                  io_bus_ready;
  logic                  io_bus_starved;
  modport slave (
    input  io_core_r_addr, io_core_r_enable,
    input  io_core_rw_addr, io_core_rw_enable, io_core_rw_write, io_core_rw_byte_en, io_core_rw_data_in,
    input  io_bus_addr, io_bus_enable, io_bus_write, io_bus_data_in,
    output io_core_r_data_out, io_core_rw_data_out, io_bus_data_out, io_bus_ready, io_bus_starved
  );
  modport master (
    output io_core_r_addr, io_core_r_enable,
    output io_core_rw_addr, io_core_rw_enable, io_core_rw_write, io_core_rw_byte_en, io_core_rw_data_in,
    output io_bus_addr, io_bus_enable, io_bus_write, io_bus_data_in,
    input  io_core_r_data_out, io_core_rw_data_out, io_bus_data_out, io_bus_ready, io_bus_starved
  );
endinterface

// File: rtl/ispm_shared_bank.sv
// ispm_bank: one byte lane (clk, rst; port A registered read-only, port B read-first with write enable)
module ispm_bank #(parameter int ADDR_BITS = 12) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] i_a_addr,
  input  logic                 i_a_en,
  output logic [7:0]           o_a_data,
  input  logic [ADDR_BITS-1:0] i_b_addr,
  input  logic                 i_b_we,
  input  logic [7:0]           i_b_data,
  output logic [7:0]           o_b_data
);
  logic [7:0] r_mem [2**ADDR_BITS];
  logic [7:0] r_a_data;
  always_ff @(posedge clk)
    if (i_b_we) r_mem[i_b_addr] <= i_b_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_a_data <= '0;
    else if (i_a_en) r_a_data <= r_mem[i_a_addr];
  assign o_a_data = r_a_data;
  assign o_b_data = r_mem[i_b_addr];
endmodule

// File: rtl/ispm_shared.sv
// ispm_shared: shared scratchpad (clk, reset, io.slave: fetch port A, load/store port B, bus slave sharing port B when core idle)
module ispm_shared
  import ispm_pkg::*;
#(
  parameter int ADDR_BITS    = 12,
  parameter int DATA_BYTES   = 4,
  parameter int STARVE_LIMIT = 16
) (
  input logic clk,
  input logic reset,
  ispm_shared_if.slave io
);
  localparam int DW = 8 * DATA_BYTES;
  localparam int CW = starve_cnt_bits(STARVE_LIMIT);
  bus_state_e            r_state, w_next;
  logic [CW-1:0]         r_starve;
  logic [DW-1:0]         r_rw_data, r_bus_data, w_a_data, w_b_rdata, w_b_wdata;
  logic [ADDR_BITS-1:0]  w_b_addr;
  logic [DATA_BYTES-1:0] w_b_we;
  logic                  w_bus_go, w_blocked, w_ready, w_starved;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == RESP || !io.io_bus_enable) ? IDLE : io.io_core_rw_enable ? WAIT : RESP;
  always_comb begin
    w_bus_go  = r_state != RESP && io.io_bus_enable && !io.io_core_rw_enable;
    w_blocked = r_state != RESP && io.io_bus_enable && io.io_core_rw_enable;
    w_ready   = r_state == RESP;
    w_starved = r_starve == CW'(STARVE_LIMIT);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_starve <= '0;
    else if (w_blocked) r_starve <= w_starved ? r_starve : r_starve + 1'b1;
    else if (!w_bus_go) r_starve <= '0;
  always_comb begin
    w_b_addr  = io.io_core_rw_enable ? io.io_core_rw_addr : io.io_bus_addr;
    w_b_wdata = io.io_core_rw_enable ? io.io_core_rw_data_in : io.io_bus_data_in;
    w_b_we    = io.io_core_rw_enable ? (io.io_core_rw_write ? io.io_core_rw_byte_en : '0)
                                     : {DATA_BYTES{w_bus_go && io.io_bus_write}};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_rw_data  <= '0;
      r_bus_data <= '0;
    end else begin
      if (io.io_core_rw_enable) r_rw_data <= w_b_rdata;
      if (w_bus_go && !io.io_bus_write) r_bus_data <= w_b_rdata;
    end
  for (genvar i = 0; i < DATA_BYTES; i++) begin : g_lane
    ispm_bank #(.ADDR_BITS(ADDR_BITS)) u_bank (
      .clk      (clk),
      .rst      (reset),
      .i_a_addr (io.io_core_r_addr),
      .i_a_en   (io.io_core_r_enable),
      .o_a_data (w_a_data[8*i +: 8]),
      .i_b_addr (w_b_addr),
      .i_b_we   (w_b_we[i]),
      .i_b_data (w_b_wdata[8*i +: 8]),
      .o_b_data (w_b_rdata[8*i +: 8])
    );
  end
  assign io.io_core_r_data_out  = w_a_data;
  assign io.io_core_rw_data_out = r_rw_data;
  assign io.io_bus_data_out     = r_bus_data;
  assign io.io_bus_ready        = w_ready;
  assign io.io_bus_starved      = w_starved;
endmodule

// File: tb/tb_ispm_shared.sv
// tb_ispm_shared: directed vector table, reset-mid-WAIT sequence and randomized traffic against a memory/transaction model
module tb_ispm_shared;
  localparam int AB = 12, DB = 4, L = 4;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  ispm_shared_if #(.ADDR_BITS(AB), .DATA_BYTES(DB)) bus ();
  ispm_shared #(.ADDR_BITS(AB), .DATA_BYTES(DB), .STARVE_LIMIT(L)) dut (.clk(clk), .reset(reset), .io(bus));
  int errors = 0, checks = 0;
  typedef struct {
    logic r_en; logic [11:0] r_addr;
    logic rw_en; logic rw_wr; logic [3:0] be; logic [11:0] rw_addr; logic [31:0] rw_din;
    logic b_en; logic b_wr; logic [11:0] b_addr; logic [31:0] b_din;
    logic [31:0] e_r; logic [31:0] e_rw; logic [31:0] e_bus; logic e_rdy; logic e_stv;
  } vec_t;
  vec_t tbl[$];
  logic [31:0] mem_m [4096];
  logic [31:0] m_r, m_rw, m_bus;
  logic m_resp;
  int m_blocked;
  bit b_hold;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if ($isunknown(exp)) return;
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [31:0] er, input logic [31:0] erw, input logic [31:0] eb, input logic rdy, input logic stv);
    chk({tag, " r_data"}, bus.io_core_r_data_out, er);
    chk({tag, " rw_data"}, bus.io_core_rw_data_out, erw);
    chk({tag, " bus_data"}, bus.io_bus_data_out, eb);
    chk({tag, " ready"}, 32'(bus.io_bus_ready), 32'(rdy));
    chk({tag, " starved"}, 32'(bus.io_bus_starved), 32'(stv));
  endtask
  task automatic apply(input vec_t v);
    bus.io_core_r_enable = v.r_en;     bus.io_core_r_addr = v.r_addr;
    bus.io_core_rw_enable = v.rw_en;   bus.io_core_rw_write = v.rw_wr;
    bus.io_core_rw_byte_en = v.be;     bus.io_core_rw_addr = v.rw_addr;
    bus.io_core_rw_data_in = v.rw_din;
    bus.io_bus_enable = v.b_en;        bus.io_bus_write = v.b_wr;
    bus.io_bus_addr = v.b_addr;        bus.io_bus_data_in = v.b_din;
  endtask
  task automatic idle();
    bus.io_core_r_enable = 1'b0; bus.io_core_rw_enable = 1'b0; bus.io_bus_enable = 1'b0;
    bus.io_core_rw_write = 1'b0; bus.io_bus_write = 1'b0; bus.io_core_rw_byte_en = '0;
    bus.io_core_r_addr = '0; bus.io_core_rw_addr = '0; bus.io_bus_addr = '0;
    bus.io_core_rw_data_in = '0; bus.io_bus_data_in = '0;
  endtask
  task automatic model_edge();
    logic go;
    go = 1'b0;
    if (bus.io_core_r_enable) m_r = mem_m[bus.io_core_r_addr];
    if (bus.io_core_rw_enable) m_rw = mem_m[bus.io_core_rw_addr];
    if (m_resp) begin
      m_resp = 1'b0;
      m_blocked = 0;
    end else if (!bus.io_bus_enable) m_blocked = 0;
    else if (bus.io_core_rw_enable) m_blocked = (m_blocked < L) ? m_blocked + 1 : L;
    else begin
      go = 1'b1;
      m_resp = 1'b1;
      if (!bus.io_bus_write) m_bus = mem_m[bus.io_bus_addr];
    end
    if (bus.io_core_rw_enable && bus.io_core_rw_write)
      for (int b = 0; b < DB; b++)
        if (bus.io_core_rw_byte_en[b]) mem_m[bus.io_core_rw_addr][8*b +: 8] = bus.io_core_rw_data_in[8*b +: 8];
    if (go && bus.io_bus_write) mem_m[bus.io_bus_addr] = bus.io_bus_data_in;
  endtask
  task automatic model_step(input string tag);
    model_edge();
    @(posedge clk); #1;
    chk_all(tag, m_r, m_rw, m_bus, m_resp, 1'(m_blocked == L));
  endtask
  initial begin
    idle();
    // bus writes seed the directed addresses without touching rw_data_out
    tbl.push_back('{0,0, 0,0,0,0,0, 1,1,'h010,'h0,        0,0,0,1,0});
    tbl.push_back('{0,0, 0,0,0,0,0, 0,0,0,0,               0,0,0,0,0});
    tbl.push_back('{0,0, 0,0,0,0,0, 1,1,'h020,'h11223344, 0,0,0,1,0});
    tbl.push_back('{0,0, 0,0,0,0,0, 0,0,0,0,               0,0,0,0,0});
    tbl.push_back('{0,0, 0,0,0,0,0, 1,1,'h030,'h1,        0,0,0,1,0});
    tbl.push_back('{0,0, 0,0,0,0,0, 0,0,0,0,               0,0,0,0,0});
    tbl.push_back('{0,0, 0,0,0,0,0, 1,1,'h040,'hCAFEF00D, 0,0,0,1,0});
    tbl.push_back('{0,0, 0,0,0,0,0, 0,0,0,0,               0,0,0,0,0});
    tbl.push_back('{0,0, 0,0,0,0,0, 1,1,'h050,'h0,        0,0,0,1,0});
    tbl.push_back('{0,0, 0,0,0,0,0, 0,0,0,0,               0,0,0,0,0});
    // core write then fetch
    tbl.push_back('{0,0,      1,1,'hF,'h010,'hDEADBEEF, 0,0,0,0, 0,0,0,0,0});
    tbl.push_back('{1,'h010,  0,0,0,0,0,                0,0,0,0, 'hDEADBEEF,0,0,0,0});
    // byte enables
    tbl.push_back('{0,0,      1,1,'h5,'h020,'hAABBCCDD, 0,0,0,0, 'hDEADBEEF,'h11223344,0,0,0});
    tbl.push_back('{0,0,      1,0,0,'h020,0,            0,0,0,0, 'hDEADBEEF,'h11BB33DD,0,0,0});
    // read-first collision
    tbl.push_back('{1,'h030,  1,1,'hF,'h030,'h2,        0,0,0,0, 'h1,'h1,0,0,0});
    tbl.push_back('{1,'h030,  1,0,0,'h030,0,            0,0,0,0, 'h2,'h2,0,0,0});
    // uncontended bus read
    tbl.push_back('{0,0, 0,0,0,0,0, 1,0,'h040,0, 'h2,'h2,'hCAFEF00D,1,0});
    tbl.push_back('{0,0, 0,0,0,0,0, 0,0,0,0,     'h2,'h2,'hCAFEF00D,0,0});
    // contention and starvation
    for (int k = 1; k <= 6; k++)
      tbl.push_back('{0,0, 1,0,0,'h010,0, 1,1,'h050,'h5, 'h2,'hDEADBEEF,'hCAFEF00D,0,(k >= L)});
    tbl.push_back('{0,0, 0,0,0,0,0,      1,1,'h050,'h5, 'h2,'hDEADBEEF,'hCAFEF00D,1,1});
    tbl.push_back('{0,0, 0,0,0,0,0,      0,0,0,0,       'h2,'hDEADBEEF,'hCAFEF00D,0,0});
    tbl.push_back('{0,0, 1,0,0,'h050,0,  0,0,0,0,       'h2,'h5,'hCAFEF00D,0,0});
    // write with no byte enables is a read
    tbl.push_back('{0,0, 1,1,0,'h050,'hFFFFFFFF, 0,0,0,0, 'h2,'h5,'hCAFEF00D,0,0});
    tbl.push_back('{0,0, 1,0,0,'h050,0,          0,0,0,0, 'h2,'h5,'hCAFEF00D,0,0});
    // request abandoned in WAIT, then a clean read
    tbl.push_back('{0,0, 1,0,0,'h010,0, 1,0,'h040,0, 'h2,'hDEADBEEF,'hCAFEF00D,0,0});
    tbl.push_back('{0,0, 0,0,0,0,0,     0,0,0,0,     'h2,'hDEADBEEF,'hCAFEF00D,0,0});
    tbl.push_back('{0,0, 0,0,0,0,0,     1,0,'h020,0, 'h2,'hDEADBEEF,'h11BB33DD,1,0});
    tbl.push_back('{0,0, 0,0,0,0,0,     0,0,0,0,     'h2,'hDEADBEEF,'h11BB33DD,0,0});
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(posedge clk); #1;
      chk_all($sformatf("row%0d", i), tbl[i].e_r, tbl[i].e_rw, tbl[i].e_bus, tbl[i].e_rdy, tbl[i].e_stv);
    end
    // reset while the bus waits behind the core
    idle();
    bus.io_core_rw_enable = 1'b1; bus.io_core_rw_addr = 12'h010;
    bus.io_bus_enable = 1'b1; bus.io_bus_write = 1'b1; bus.io_bus_addr = 12'h060; bus.io_bus_data_in = 32'h77;
    repeat (2) begin
      @(posedge clk); #1;
      chk("wait ready", 32'(bus.io_bus_ready), 32'd0);
    end
    #2 reset = 1'b1;
    #1 chk_all("async reset", 0, 0, 0, 0, 0);
    bus.io_core_rw_enable = 1'b0; bus.io_bus_write = 1'b0; bus.io_bus_addr = 12'h050;
    @(posedge clk); #1;
    chk_all("held reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk_all("post reset req", 0, 0, 32'h5, 1, 0);
    idle();
    @(posedge clk); #1;
    chk_all("post reset idle", 0, 0, 32'h5, 0, 0);
    // randomized traffic on a small address window
    for (int a = 0; a < 4096; a++) mem_m[a] = 'x;
    m_r = 0; m_rw = 0; m_bus = 32'h5; m_resp = 1'b0; m_blocked = 0; b_hold = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bus.io_core_rw_enable = 1'b1; bus.io_core_rw_write = 1'b1; bus.io_core_rw_byte_en = 4'hF;
      bus.io_core_rw_addr = 12'h100 + 12'(a); bus.io_core_rw_data_in = $urandom;
      model_step("init");
    end
    for (int c = 0; c < 400; c++) begin
      bus.io_core_r_enable = 1'($urandom_range(0, 1));
      bus.io_core_r_addr = 12'h100 + 12'($urandom_range(0, 7));
      bus.io_core_rw_enable = 1'($urandom_range(0, 9) < 6);
      bus.io_core_rw_write = 1'($urandom_range(0, 1));
      bus.io_core_rw_byte_en = 4'($urandom_range(0, 15));
      bus.io_core_rw_addr = 12'h100 + 12'($urandom_range(0, 7));
      bus.io_core_rw_data_in = $urandom;
      if (!b_hold && $urandom_range(0, 3) == 0) begin
        b_hold = 1'b1;
        bus.io_bus_enable = 1'b1;
        bus.io_bus_write = 1'($urandom_range(0, 1));
        bus.io_bus_addr = 12'h100 + 12'($urandom_range(0, 7));
        bus.io_bus_data_in = $urandom;
      end
      model_step($sformatf("rand%0d", c));
      if (bus.io_bus_ready) begin
        b_hold = 1'b0;
        bus.io_bus_enable = 1'b0;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
